sha256_compress_mr: RTL

SHA256_COMPRESS_MR -- requirements
Module: sha256_compress_mr

---
 rtl/sha256_pkg.sv | 36 +++
 rtl/sha256_round_comb.sv | 21 ++
 rtl/sha256_compress_mr.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, word type and round/schedule helper functions.
package sha256_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, FINAL, OUT} state_t;
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_round_comb.sv
// sha256_round_comb: one combinational SHA-256 compression round.
module sha256_round_comb
  import sha256_pkg::*;
(
  input  word_t a, b, c, d, e, f, g, h,
  input  word_t kt,
  input  word_t wt,
  output word_t a_next, b_next, c_next, d_next, e_next, f_next, g_next, h_next
);
  word_t t1, t2;
  assign t1 = h + bsig1(e) + ch(e, f, g) + kt + wt;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;
endmodule

// File: rtl/sha256_compress_mr.sv
// sha256_compress_mr: multi-round-per-cycle SHA-256 block compression core.
// Define SHA256_DOUBLE_HASH_EN to add in_double (second pass over the first digest).
module sha256_compress_mr
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  input  logic [511:0] in_block,
`ifdef SHA256_DOUBLE_HASH_EN
  input  logic         in_double,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] STEP = 6'(R);
  localparam logic [5:0] LAST = 6'(64 - R);
  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  state_t state;
  logic [255:0] hv, work, sum;
  logic [511:0] load_blk;
  logic [5:0] cnt;
  word_t w [16];
  word_t ext [16+R];
`ifdef SHA256_DOUBLE_HASH_EN
  logic dbl, second;
  assign load_blk = state == IDLE ? in_block : {sum, 32'h80000000, 192'h0, 32'h00000100};
`else
  assign load_blk = in_block;
`endif
  // Window plus the R schedule words needed this cycle; later words may feed on earlier new ones.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 0; j < R; j++) ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
  end
  always_comb begin
    for (int i = 0; i < 8; i++) sum[255-32*i -: 32] = hv[255-32*i -: 32] + work[255-32*i -: 32];
  end
  for (genvar i = 0; i < R; i++) begin : g
    logic [255:0] s_in, s_out;
    if (i == 0) begin : f
      assign s_in = work;
    end else begin : n
      assign s_in = g[i-1].s_out;
    end
    sha256_round_comb u_round (
      .a(s_in[255:224]), .b(s_in[223:192]), .c(s_in[191:160]), .d(s_in[159:128]),
      .e(s_in[127:96]), .f(s_in[95:64]), .g(s_in[63:32]), .h(s_in[31:0]),
      .kt(K[cnt + 6'(i)]), .wt(ext[i]),
      .a_next(s_out[255:224]), .b_next(s_out[223:192]), .c_next(s_out[191:160]), .d_next(s_out[159:128]),
      .e_next(s_out[127:96]), .f_next(s_out[95:64]), .g_next(s_out[63:32]), .h_next(s_out[31:0])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hv <= '0;
      work <= '0;
      cnt <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      out_digest <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      in_ready <= 1'b1;
`ifdef SHA256_DOUBLE_HASH_EN
      dbl <= 1'b0;
      second <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          hv <= in_state;
          work <= in_state;
          cnt <= '0;
          for (int i = 0; i < 16; i++) w[i] <= load_blk[511-32*i -: 32];
`ifdef SHA256_DOUBLE_HASH_EN
          dbl <= in_double;
          second <= 1'b0;
`endif
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          work <= g[R-1].s_out;
          for (int i = 0; i < 16; i++) w[i] <= ext[i+R];
          cnt <= cnt + STEP;
          state <= cnt == LAST ? FINAL : RUN;
        end
        FINAL: begin
`ifdef SHA256_DOUBLE_HASH_EN
          if (dbl && !second) begin
            hv <= IV;
            work <= IV;
            cnt <= '0;
            for (int i = 0; i < 16; i++) w[i] <= load_blk[511-32*i -: 32];
            second <= 1'b1;
            state <= RUN;
          end else
`endif
          begin
            out_digest <= sum;
            out_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
